imm_ext_unit: RTL and testbench

- Registered immediate generator for the multi-cycle RV32I core. It is the consumer side of the decoder's immSrc encoding.
- Takes the 32-bit instruction and the 3-bit imm_src select from the decoder, and produces the sign-extended 32-bit immediate for ALU operand B and the PC-target adder.
- One pipeline register with a valid/ready handshake on both sides, so it can sit between decode and execute states and stall cleanly.
- Keeps a saturating count of illegal imm_src encodings for debug.

---
 rtl/imm_ext_unit.sv | 79 +++++++
 tb/tb_imm_ext_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/imm_ext_unit.sv
// Registered RV32I immediate generator with valid/ready handshake on both sides.
// Decodes imm_src into the sign-extended immediate. Illegal selects produce zero,
// raise imm_err and bump a saturating debug counter.
module imm_ext_unit #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [2:0]           imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          imm_ext,
  output logic                 imm_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e               state_q;
  logic [31:0]          imm_q;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic [31:0] imm_d;
  logic        err_d;
  logic        accept;

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign imm_ext = imm_q;
  assign imm_err = err_q;
  assign err_cnt = err_cnt_q;

  // Decode the immediate format into a sign-extended 32-bit value.
  always_comb begin
    imm_d = 32'h0;
    err_d = 1'b0;
    unique case (imm_src)
      3'b000: imm_d = {{20{instr[31]}}, instr[31:20]};
      3'b001: imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100: imm_d = {instr[31:12], 12'h000};
      default: begin
        imm_d = 32'h0;
        err_d = 1'b1;
      end
    endcase
  end

  // Output register, occupancy state and saturating illegal-select counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      imm_q     <= 32'h0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (accept) begin
        imm_q <= imm_d;
        err_q <= err_d;
        if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
          err_cnt_q <= err_cnt_q + 1'b1;
        end
      end
      unique case (state_q)
        StEmpty: if (accept) state_q <= StFull;
        StFull:  if (out_ready && !accept) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: reset, back-to-back formats, stall, illegal
// selects, drain, and counter saturation on a narrow-counter instance.
module tb_imm_ext_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_ext;
  logic        imm_err;
  logic [7:0]  err_cnt;

  logic        s_valid;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_imm_ext;
  logic        s_imm_err;
  logic [1:0]  s_err_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  imm_ext_unit #(.ERR_CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .imm_src   (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_ext   (imm_ext),
    .imm_err   (imm_err),
    .err_cnt   (err_cnt)
  );

  imm_ext_unit #(.ERR_CNT_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_valid),
    .in_ready  (s_in_ready),
    .instr     (instr),
    .imm_src   (imm_src),
    .out_valid (s_out_valid),
    .out_ready (1'b1),
    .imm_ext   (s_imm_ext),
    .imm_err   (s_imm_err),
    .err_cnt   (s_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    s_valid   = 1'b0;
    out_ready = 1'b0;
    instr     = 32'h0;
    imm_src   = 3'b000;
    step();
    step();
    reset = 1'b0;

    // Fill with an illegal result and stall, then reset over it.
    in_valid = 1'b1;
    imm_src  = 3'b111;
    step();
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'h1);
    check("pre_reset_cnt", 32'(err_cnt), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_imm_ext", imm_ext, 32'h0);
    check("rst_imm_err", 32'(imm_err), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back accepts with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr = 32'hFFF00093; imm_src = 3'b000;
    step();
    check("b2b_i_valid", 32'(out_valid), 32'h1);
    check("b2b_i", imm_ext, 32'hFFFFFFFF);
    instr = 32'hFE112E23; imm_src = 3'b001;
    step();
    check("b2b_s", imm_ext, 32'hFFFFFFFC);
    instr = 32'hFE000CE3; imm_src = 3'b010;
    step();
    check("b2b_b", imm_ext, 32'hFFFFFFF8);
    instr = 32'h008000EF; imm_src = 3'b011;
    step();
    check("b2b_j", imm_ext, 32'h00000008);
    instr = 32'h123450B7; imm_src = 3'b100;
    step();
    check("b2b_u", imm_ext, 32'h12345000);
    check("b2b_u_err", 32'(imm_err), 32'h0);
    check("b2b_u_valid", 32'(out_valid), 32'h1);

    // Stall for three cycles while the I case is offered.
    out_ready = 1'b0;
    instr = 32'hFFF00093; imm_src = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", 32'(in_ready), 32'h0);
      step();
      check("stall_imm_ext", imm_ext, 32'h12345000);
      check("stall_out_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(in_ready), 32'h1);
    step();
    check("unstall_imm_ext", imm_ext, 32'hFFFFFFFF);
    check("unstall_valid", 32'(out_valid), 32'h1);

    // Illegal selects.
    for (int k = 0; k < 3; k++) begin
      imm_src = 3'(5 + k);
      step();
      check("ill_imm_ext", imm_ext, 32'h0);
      check("ill_imm_err", 32'(imm_err), 32'h1);
      check("ill_err_cnt", 32'(err_cnt), 32'(k + 1));
    end
    instr = 32'hFFF00093; imm_src = 3'b000;
    step();
    check("legal_after_ill_err", 32'(imm_err), 32'h0);
    check("legal_after_ill_imm", imm_ext, 32'hFFFFFFFF);
    check("legal_after_ill_cnt", 32'(err_cnt), 32'h3);

    // Drain without a new accept.
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_imm_hold", imm_ext, 32'hFFFFFFFF);
    check("drain_in_ready", 32'(in_ready), 32'h1);

    // Saturation on the 2-bit counter instance.
    s_valid = 1'b1;
    imm_src = 3'b110;
    for (int k = 0; k < 5; k++) begin
      step();
      check("sat_err_cnt", 32'(s_err_cnt), (k < 3) ? 32'(k + 1) : 32'h3);
      check("sat_imm_err", 32'(s_imm_err), 32'h1);
    end
    s_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
